// File: rtl/ladybird_qspi_pkg.sv
// Shared definitions for the QSPI word adapter and the flash interface behind it:
// FSM state encoding, control-space command offsets, and small address/strobe helpers.
package ladybird_qspi_pkg;

  // Adapter sequencing states.
  typedef enum logic [3:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WREN_ISSUE,
    WREN_WAIT,
    PROG_ISSUE,
    PROG_WAIT,
    POLL_ISSUE,
    POLL_WAIT,
    PASS_ISSUE,
    PASS_WAIT,
    RESP
  } state_t;

  // Address bit that selects control space over flash space.
  localparam int CTRL_SPACE_BIT = 16;

  // Write-in-progress bit of the flash status register.
  localparam int WIP_BIT = 0;

  // Control-space command offsets (addr[2:0]), shared with the flash interface.
  localparam logic [2:0] OFS_REMS0 = 3'b000;
  localparam logic [2:0] OFS_REMS1 = 3'b001;
  localparam logic [2:0] OFS_RDSR  = 3'b010;
  localparam logic [2:0] OFS_RDCR  = 3'b011;
  localparam logic [2:0] OFS_WRR   = 3'b100;
  localparam logic [2:0] OFS_WREN  = 3'b101;

  // Base address of control space.
  localparam logic [31:0] CTRL_BASE = 32'h0001_0000;

  // Byte address inside flash space for byte lane idx of a word address.
  function automatic logic [31:0] flash_byte_addr(input logic [15:0] word_addr,
                                                  input logic [1:0]  idx);
    return {16'd0, word_addr[15:2], idx};
  endfunction

  // Lowest set strobe bit at or above position from.
  // Result[2] = 1 means no such bit; otherwise result[1:0] is its index.
  function automatic logic [2:0] next_strobe(input logic [3:0] strb,
                                             input logic [2:0] from);
    logic [2:0] res;
    res = 3'b100;
    for (int i = 3; i >= 0; i--) begin
      if (strb[i] && (3'(i) >= from)) res = {1'b0, 2'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/ladybird_qspi_xact.sv
// Completion tracker for one downstream flash-interface transaction.
// Reads complete on f_data_gnt; writes complete once f_gnt has been seen low
// after issue and has then come back high (the interface went busy and returned idle).
module ladybird_qspi_xact
  import ladybird_qspi_pkg::*;
(
  input  logic sck,
  input  logic nrst,
  input  logic f_req,
  input  logic f_gnt,
  input  logic f_data_gnt,
  input  logic waiting,
  input  logic wait_data,
  output logic done
);

  logic seen_busy;

  // Remember that the interface went busy since the last accepted request.
  // NOTE: sequential state uses non-blocking assignments, and nrst is a synchronous
  // reset sampled only on the sck edge, so it sits inside the clocked branch.
  always_ff @(posedge sck) begin
    if (!nrst) begin
      seen_busy <= 1'b0;
    end else if (f_req && f_gnt) begin
      seen_busy <= 1'b0;
    end else if (waiting && !f_gnt) begin
      seen_busy <= 1'b1;
    end
  end

  assign done = waiting && (wait_data ? f_data_gnt : (seen_busy && f_gnt));

endmodule

// File: rtl/ladybird_qspi_word_adapter.sv
// Word-to-byte adapter in front of the QSPI flash interface (sck domain).
// Flash reads become four byte reads assembled little-endian; flash writes become
// WREN / PROGRAM / RDSR-poll per strobed byte; control-space accesses pass through.
module ladybird_qspi_word_adapter
  import ladybird_qspi_pkg::*;
#(
  parameter int         POLL_MAX      = 1024,
  parameter logic [2:0] CTRL_WREN_OFS = OFS_WREN,
  parameter logic [2:0] CTRL_RDSR_OFS = OFS_RDSR
) (
  input  logic        sck,
  input  logic        nrst,
  input  logic        req,
  output logic        gnt,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        err,
  output logic        f_req,
  input  logic        f_gnt,
  output logic [31:0] f_addr,
  output logic [3:0]  f_wstrb,
  output logic [31:0] f_wdata,
  input  logic [31:0] f_rdata,
  input  logic        f_data_gnt
);

  localparam int            PW        = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
  localparam logic [31:0]   WREN_ADDR = CTRL_BASE | {29'd0, CTRL_WREN_OFS};
  localparam logic [31:0]   RDSR_ADDR = CTRL_BASE | {29'd0, CTRL_RDSR_OFS};

  state_t        state;
  logic [15:0]   lat_addr;
  logic [3:0]    lat_wstrb;
  logic [31:0]   lat_wdata;
  logic [1:0]    byte_idx;
  logic [PW-1:0] poll_cnt;

  logic          waiting;
  logic          wait_data;
  logic          done;
  logic          pass_nowait;
  logic [2:0]    first_byte;
  logic [2:0]    next_byte;

  assign waiting   = (state == RD_WAIT)   || (state == WREN_WAIT) ||
                     (state == PROG_WAIT) || (state == POLL_WAIT) ||
                     (state == PASS_WAIT);
  assign wait_data = (state == RD_WAIT) || (state == POLL_WAIT) ||
                     ((state == PASS_WAIT) && (lat_wstrb == 4'd0));

  // Control writes other than WRR/WREN never make the interface busy,
  // so there is no completion to wait for.
  assign pass_nowait = (lat_wstrb != 4'd0) &&
                       !(lat_addr[2:0] inside {OFS_WRR, OFS_WREN});

  assign first_byte = next_strobe(wstrb, 3'd0);
  assign next_byte  = next_strobe(lat_wstrb, {1'b0, byte_idx} + 3'd1);

  ladybird_qspi_xact u_xact (
    .sck        (sck),
    .nrst       (nrst),
    .f_req      (f_req),
    .f_gnt      (f_gnt),
    .f_data_gnt (f_data_gnt),
    .waiting    (waiting),
    .wait_data  (wait_data),
    .done       (done)
  );

  // Main sequencer: accepts a core access, walks its downstream transactions, responds.
  always_ff @(posedge sck) begin
    if (!nrst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      rvalid    <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      f_req     <= 1'b0;
      f_addr    <= '0;
      f_wstrb   <= '0;
      f_wdata   <= '0;
      lat_addr  <= '0;
      lat_wstrb <= '0;
      lat_wdata <= '0;
      byte_idx  <= '0;
      poll_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt && req) begin
            gnt       <= 1'b0;
            lat_addr  <= addr[15:0];
            lat_wstrb <= wstrb;
            lat_wdata <= wdata;
            poll_cnt  <= '0;
            f_req     <= 1'b1;
            if (addr[CTRL_SPACE_BIT]) begin
              f_addr  <= addr;
              f_wstrb <= wstrb;
              f_wdata <= wdata;
              state   <= PASS_ISSUE;
            end else if (wstrb == 4'd0) begin
              byte_idx <= 2'd0;
              f_addr   <= flash_byte_addr(addr[15:0], 2'd0);
              f_wstrb  <= 4'd0;
              f_wdata  <= '0;
              state    <= RD_ISSUE;
            end else begin
              byte_idx <= first_byte[1:0];
              f_addr   <= WREN_ADDR;
              f_wstrb  <= 4'b0001;
              f_wdata  <= '0;
              state    <= WREN_ISSUE;
            end
          end else begin
            gnt <= 1'b1;
          end
        end

        RD_ISSUE: begin
          if (f_gnt) begin
            f_req <= 1'b0;
            state <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (done) begin
            rdata[8*byte_idx +: 8] <= f_rdata[7:0];
            if (byte_idx == 2'd3) begin
              rvalid <= 1'b1;
              err    <= 1'b0;
              state  <= RESP;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              f_addr   <= flash_byte_addr(lat_addr, byte_idx + 2'd1);
              f_req    <= 1'b1;
              state    <= RD_ISSUE;
            end
          end
        end

        WREN_ISSUE: begin
          if (f_gnt) begin
            f_req <= 1'b0;
            state <= WREN_WAIT;
          end
        end

        WREN_WAIT: begin
          if (done) begin
            f_addr  <= flash_byte_addr(lat_addr, byte_idx);
            f_wdata <= {24'd0, lat_wdata[8*byte_idx +: 8]};
            f_wstrb <= 4'b0001;
            f_req   <= 1'b1;
            state   <= PROG_ISSUE;
          end
        end

        PROG_ISSUE: begin
          if (f_gnt) begin
            f_req <= 1'b0;
            state <= PROG_WAIT;
          end
        end

        PROG_WAIT: begin
          if (done) begin
            f_addr   <= RDSR_ADDR;
            f_wstrb  <= 4'd0;
            f_wdata  <= '0;
            f_req    <= 1'b1;
            poll_cnt <= '0;
            state    <= POLL_ISSUE;
          end
        end

        POLL_ISSUE: begin
          if (f_gnt) begin
            f_req <= 1'b0;
            state <= POLL_WAIT;
          end
        end

        POLL_WAIT: begin
          if (done) begin
            if (!f_rdata[WIP_BIT]) begin
              if (next_byte[2]) begin
                rvalid <= 1'b1;
                err    <= 1'b0;
                state  <= RESP;
              end else begin
                byte_idx <= next_byte[1:0];
                poll_cnt <= '0;
                f_addr   <= WREN_ADDR;
                f_wstrb  <= 4'b0001;
                f_wdata  <= '0;
                f_req    <= 1'b1;
                state    <= WREN_ISSUE;
              end
            end else if (poll_cnt == POLL_LAST) begin
              poll_cnt <= poll_cnt + PW'(1);
              rvalid   <= 1'b1;
              err      <= 1'b1;
              state    <= RESP;
            end else begin
              poll_cnt <= poll_cnt + PW'(1);
              f_req    <= 1'b1;
              state    <= POLL_ISSUE;
            end
          end
        end

        PASS_ISSUE: begin
          if (f_gnt) begin
            f_req <= 1'b0;
            if (pass_nowait) begin
              rvalid <= 1'b1;
              err    <= 1'b0;
              state  <= RESP;
            end else begin
              state <= PASS_WAIT;
            end
          end
        end

        PASS_WAIT: begin
          if (done) begin
            if (lat_wstrb == 4'd0) rdata <= f_rdata;
            rvalid <= 1'b1;
            err    <= 1'b0;
            state  <= RESP;
          end
        end

        RESP: begin
          rvalid <= 1'b0;
          err    <= 1'b0;
          gnt    <= 1'b1;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
